udma_ch_rr_arbiter: RTL

UDMA_CH_RR_ARBITER -- requirements
Module: udma_ch_rr_arbiter

---
 rtl/udma_ch_rr_arbiter.sv | 81 ++++++++
 1 files changed

// File: rtl/udma_ch_rr_arbiter.sv
// Round-robin arbiter that merges the uDMA TX linear channels into one registered beat stream.
// The search starts just after the last granted channel, and the output register forms a one-deep skid stage.
module udma_ch_rr_arbiter #(
    parameter int N_CH   = 19,
    parameter int DATA_W = 32,
    parameter int ID_W   = $clog2(N_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_CH-1:0]          ch_en_i,
    input  logic [N_CH-1:0]          req_i,
    input  logic [N_CH*DATA_W-1:0]   data_i,
    output logic [N_CH-1:0]          gnt_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ID_W-1:0]          out_ch_id_o,
    output logic [DATA_W-1:0]        out_data_o
);

    logic [N_CH-1:0]   eligible;
    logic              can_load;
    logic [ID_W-1:0]   last_ptr;
    logic              found_hi;
    logic              found_lo;
    logic [ID_W-1:0]   hi_idx;
    logic [ID_W-1:0]   lo_idx;
    logic [ID_W-1:0]   sel_idx;
    logic              grant_any;
    logic [DATA_W-1:0] sel_data;

    assign eligible = req_i & ch_en_i;
    assign can_load = !out_valid_o || out_ready_i;

    // Two passes: channels above last_ptr win first; otherwise wrap to the lowest eligible index.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (eligible[k] && (k > int'(last_ptr)) && !found_hi) begin
                found_hi = 1'b1;
                hi_idx   = ID_W'(k);
            end
            if (eligible[k] && !found_lo) begin
                found_lo = 1'b1;
                lo_idx   = ID_W'(k);
            end
        end
        sel_idx   = found_hi ? hi_idx : lo_idx;
        grant_any = (found_hi || found_lo) && can_load && !rst_i;
    end

    always_comb begin
        gnt_o    = '0;
        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_idx == ID_W'(k)) begin
                gnt_o[k] = grant_any;
                sel_data = data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_ch_id_o <= '0;
            out_data_o  <= '0;
            last_ptr    <= ID_W'(N_CH - 1);
        end else if (grant_any) begin
            out_valid_o <= 1'b1;
            out_ch_id_o <= sel_idx;
            out_data_o  <= sel_data;
            last_ptr    <= sel_idx;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule
